// File: rtl/pipe_add_arb.sv
// pipe_add_arb
//   Round-robin arbiter sharing one pipelined adder (pipe_add) among NUM_REQ
//   requesters. One operand pair is granted per cycle and registered onto the
//   adder inputs. The requester ID travels down a tag pipe that runs alongside
//   the adder. When the sum emerges, it is routed back to its originator.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   req_valid       per-requester operand-pair valid
//   req_a, req_b    packed operands, requester i at [i*DATA_W +: DATA_W]
//   req_ready       one-hot combinational grant (zero while rst=1)
//   add_a, add_b    registered operands to pipe_add
//   add_sum         DATA_W+1 sum returned by pipe_add, PIPE_LAT cycles later
//   rsp_valid       one-cycle result pulse per issued op
//   rsp_id          owner of rsp_sum
//   rsp_sum         registered copy of add_sum
//   busy            an op is issuing now or is in flight
//   perf_issue_cnt  saturating issued-op counter
//
// Configuration
//   PIPE_ADD_ARB_PERF_EN  defined: perf_issue_cnt counts handshakes and
//                         saturates at 16'hFFFF. Undefined: it is tied to zero.

module pipe_add_arb #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 8,
  parameter int PIPE_LAT = 2,
  parameter int ID_W     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         add_a,
  output logic [DATA_W-1:0]         add_b,
  input  logic [DATA_W:0]           add_sum,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W:0]           rsp_sum,
  output logic                      busy,
  output logic [15:0]               perf_issue_cnt
);

  logic [ID_W-1:0]    rr_ptr_r;
  logic [NUM_REQ-1:0] valid_s;
  logic               hi_found_s;
  logic               lo_found_s;
  logic               hi_take_s;
  logic               lo_take_s;
  logic [ID_W-1:0]    hi_id_s;
  logic [ID_W-1:0]    lo_id_s;
  logic [ID_W-1:0]    win_id_s;
  logic               hs_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [DATA_W-1:0]  sel_a_s;
  logic [DATA_W-1:0]  sel_b_s;

  logic [DATA_W-1:0]  add_a_r;
  logic [DATA_W-1:0]  add_b_r;
  logic [PIPE_LAT:0]  tag_vld_r;
  logic [ID_W-1:0]    tag_id_r [PIPE_LAT+1];
  logic               rsp_valid_r;
  logic [ID_W-1:0]    rsp_id_r;
  logic [DATA_W:0]    rsp_sum_r;

  // Round-robin search: the first valid at or above rr_ptr wins; if none,
  // the lowest valid overall wins (this is the wrap-around part of the search).
  always_comb begin
    valid_s    = rst ? '0 : req_valid;
    hi_found_s = 1'b0;
    lo_found_s = 1'b0;
    hi_take_s  = 1'b0;
    lo_take_s  = 1'b0;
    hi_id_s    = '0;
    lo_id_s    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hi_take_s  = valid_s[i] & ~hi_found_s & (ID_W'(i) >= rr_ptr_r);
      lo_take_s  = valid_s[i] & ~lo_found_s;
      hi_id_s    = hi_take_s ? ID_W'(i) : hi_id_s;
      lo_id_s    = lo_take_s ? ID_W'(i) : lo_id_s;
      hi_found_s = hi_found_s | hi_take_s;
      lo_found_s = lo_found_s | lo_take_s;
    end
    hs_s     = lo_found_s;
    win_id_s = hi_found_s ? hi_id_s : lo_id_s;
  end

  // One-hot grant and AND-OR operand mux for the winner.
  always_comb begin
    grant_s = '0;
    sel_a_s = '0;
    sel_b_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_s[i] = hs_s & (win_id_s == ID_W'(i));
      sel_a_s    = sel_a_s | (req_a[i*DATA_W +: DATA_W] & {DATA_W{grant_s[i]}});
      sel_b_s    = sel_b_s | (req_b[i*DATA_W +: DATA_W] & {DATA_W{grant_s[i]}});
    end
  end

  // Issue registers, round-robin pointer, tag pipe and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r    <= '0;
      add_a_r     <= '0;
      add_b_r     <= '0;
      tag_vld_r   <= '0;
      for (int i = 0; i <= PIPE_LAT; i++) begin
        tag_id_r[i] <= '0;
      end
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= '0;
      rsp_sum_r   <= '0;
    end else begin
      if (hs_s) begin
        add_a_r  <= sel_a_s;
        add_b_r  <= sel_b_s;
        rr_ptr_r <= (win_id_s == ID_W'(NUM_REQ-1)) ? ID_W'(0) : win_id_s + ID_W'(1);
      end
      // The tag pipe never stalls, matching the adder; an idle cycle shifts in a bubble.
      tag_vld_r   <= {tag_vld_r[PIPE_LAT-1:0], hs_s};
      tag_id_r[0] <= win_id_s;
      for (int i = 1; i <= PIPE_LAT; i++) begin
        tag_id_r[i] <= tag_id_r[i-1];
      end
      // The last tag stage lines up with add_sum being valid.
      rsp_valid_r <= tag_vld_r[PIPE_LAT];
      if (tag_vld_r[PIPE_LAT]) begin
        rsp_sum_r <= add_sum;
        rsp_id_r  <= tag_id_r[PIPE_LAT];
      end
    end
  end

`ifdef PIPE_ADD_ARB_PERF_EN
  logic [15:0] perf_cnt_r;

  // Saturating count of handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt_r <= 16'd0;
    end else if (hs_s && (perf_cnt_r != 16'hFFFF)) begin
      perf_cnt_r <= perf_cnt_r + 16'd1;
    end
  end

  assign perf_issue_cnt = perf_cnt_r;
`else
  assign perf_issue_cnt = 16'd0;
`endif

  assign req_ready = grant_s;
  assign add_a     = add_a_r;
  assign add_b     = add_b_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_sum   = rsp_sum_r;
  assign busy      = ~rst & ((|tag_vld_r) | hs_s);

endmodule

// File: tb/tb_pipe_add_arb.sv
// Self-checking bench for pipe_add_arb with a behavioural 2-cycle pipe_add.
// A negedge reference model predicts grants, busy, responses and the counter.
// Each scenario task also makes its own directed checks.

module tb_pipe_add_arb;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int ID_W    = 2;
`ifdef PIPE_ADD_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ*DATA_W-1:0] req_a = '0;
  logic [NUM_REQ*DATA_W-1:0] req_b = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         add_a;
  logic [DATA_W-1:0]         add_b;
  logic [DATA_W:0]           add_sum;
  logic                      rsp_valid;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W:0]           rsp_sum;
  logic                      busy;
  logic [15:0]               perf_issue_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_add_arb dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .busy(busy),
    .perf_issue_cnt(perf_issue_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural pipe_add: two register stages from add_a/add_b to add_sum.
  logic [DATA_W:0] add_s1;
  always @(posedge clk) begin
    add_s1  <= {1'b0, add_a} + {1'b0, add_b};
    add_sum <= add_s1;
  end

  // ---------------- reference model (cycle = negedge index) ----------------
  bit              mon_en = 1'b0;
  int              cyc = 0;
  int              m_ptr = 0;
  int              m_cnt = 0;
  bit              exp_v   [0:4095];
  logic [ID_W-1:0] exp_id  [0:4095];
  logic [DATA_W:0] exp_sum [0:4095];
  bit              hs_hist [0:4095];
  logic [NUM_REQ-1:0] eg;
  bit              ehs;
  bit              eb;
  int              ewin;
  int              idx;

  always @(negedge clk) begin
    if (mon_en) begin
      eg = '0; ehs = 1'b0; ewin = 0;
      if (!rst) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          idx = (m_ptr + k) % NUM_REQ;
          if (!ehs && req_valid[idx]) begin ehs = 1'b1; ewin = idx; end
        end
      end
      if (ehs) eg[ewin] = 1'b1;
      n_tests++;
      if (req_ready !== eg) begin
        n_fail++; $display("FAIL model_grant cyc=%0d got=%b exp=%b", cyc, req_ready, eg);
      end
      eb = !rst && (ehs || (cyc >= 1 && hs_hist[cyc-1]) || (cyc >= 2 && hs_hist[cyc-2])
                        || (cyc >= 3 && hs_hist[cyc-3]));
      n_tests++;
      if (busy !== eb) begin
        n_fail++; $display("FAIL model_busy cyc=%0d got=%b exp=%b", cyc, busy, eb);
      end
      n_tests++;
      if (rsp_valid !== exp_v[cyc]) begin
        n_fail++; $display("FAIL model_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_v[cyc]);
      end
      if (exp_v[cyc]) begin
        n_tests++;
        if (rsp_id !== exp_id[cyc] || rsp_sum !== exp_sum[cyc]) begin
          n_fail++;
          $display("FAIL model_rsp cyc=%0d got id=%0d sum=%0d exp id=%0d sum=%0d",
                   cyc, rsp_id, rsp_sum, exp_id[cyc], exp_sum[cyc]);
        end
      end
      n_tests++;
      if (perf_issue_cnt !== (PERF ? 16'(m_cnt) : 16'd0)) begin
        n_fail++; $display("FAIL model_perf cyc=%0d got=%0d exp=%0d", cyc, perf_issue_cnt,
                           PERF ? m_cnt : 0);
      end
      hs_hist[cyc] = ehs;
      if (ehs) begin
        exp_v[cyc+4]   = 1'b1;
        exp_id[cyc+4]  = ID_W'(ewin);
        exp_sum[cyc+4] = {1'b0, req_a[ewin*DATA_W +: DATA_W]} + {1'b0, req_b[ewin*DATA_W +: DATA_W]};
        m_ptr = (ewin + 1) % NUM_REQ;
        if (m_cnt != 65535) m_cnt++;
      end
      if (rst) begin
        for (int j = 1; j <= 8; j++) exp_v[cyc+j] = 1'b0;
        for (int j = 0; j <= 3; j++) if (cyc >= j) hs_hist[cyc-j] = 1'b0;
        m_ptr = 0;
        m_cnt = 0;
      end
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops;
    req_a = $urandom;
    req_b = $urandom;
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst = 1'b1;
    req_valid = '1;
    rand_ops();
    tick();
    mon_en = 1'b1;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || busy !== 1'b0 || perf_issue_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state ready=%b rsp_valid=%b busy=%b perf=%0d (want 0000/0/0/0)",
               req_ready, rsp_valid, busy, perf_issue_cnt);
    end
    tick();
    rst = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_single;
    req_a[7:0] = 8'd10;
    req_b[7:0] = 8'd20;
    req_valid = 4'b0001;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL single_grant got=%b exp=0001", req_ready);
    end
    tick();
    req_valid = '0;
    repeat (2) tick();
    @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_early got rsp_valid=%b exp=0", rsp_valid);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 9'd30) begin
      n_fail++;
      $display("FAIL single_rsp got v=%b id=%0d sum=%0d exp v=1 id=0 sum=30", rsp_valid, rsp_id, rsp_sum);
    end
    tick();
  endtask

  task automatic test_round_robin;
    logic [DATA_W:0] sums [0:7];
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      if (i < 8) begin
        rand_ops();
        req_valid = '1;
      end else begin
        req_valid = '0;
      end
      @(negedge clk);
      if (i < 8) begin
        sums[i] = {1'b0, req_a[(i%4)*DATA_W +: DATA_W]} + {1'b0, req_b[(i%4)*DATA_W +: DATA_W]};
        n_tests++;
        if (req_ready !== 4'(1 << (i % 4))) begin
          n_fail++; $display("FAIL rr_grant i=%0d got=%b exp=%b", i, req_ready, 4'(1 << (i % 4)));
        end
      end
      if (i >= 4) begin
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_id !== ID_W'((i-4) % 4) || rsp_sum !== sums[i-4]) begin
          n_fail++;
          $display("FAIL rr_rsp i=%0d got v=%b id=%0d sum=%0d exp v=1 id=%0d sum=%0d",
                   i, rsp_valid, rsp_id, rsp_sum, (i-4) % 4, sums[i-4]);
        end
      end
      tick();
    end
  endtask

  task automatic test_wrap_skip;
    apply_reset();
    rand_ops();
    req_valid = 4'b1000;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 4'b1000) begin
      n_fail++; $display("FAIL wrap_grant3 got=%b exp=1000", req_ready);
    end
    tick();
    req_a[15:8] = 8'd15; req_b[15:8] = 8'd25;
    req_a[23:16] = 8'd30; req_b[23:16] = 8'd40;
    req_valid = 4'b0110;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL wrap_grant1 got=%b exp=0010", req_ready);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL wrap_grant2 got=%b exp=0100", req_ready);
    end
    tick();
    req_valid = '0;
    repeat (2) tick();
    @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 9'd40) begin
      n_fail++; $display("FAIL wrap_rsp1 got v=%b id=%0d sum=%0d exp v=1 id=1 sum=40", rsp_valid, rsp_id, rsp_sum);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 9'd70) begin
      n_fail++; $display("FAIL wrap_rsp2 got v=%b id=%0d sum=%0d exp v=1 id=2 sum=70", rsp_valid, rsp_id, rsp_sum);
    end
    tick();
  endtask

  task automatic test_overflow;
    req_a[23:16] = 8'd255;
    req_b[23:16] = 8'd255;
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    repeat (3) tick();
    @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 9'd510) begin
      n_fail++; $display("FAIL overflow_rsp got v=%b id=%0d sum=%0d exp v=1 id=2 sum=510", rsp_valid, rsp_id, rsp_sum);
    end
    tick();
  endtask

  task automatic test_reset_midflight;
    apply_reset();
    rand_ops();
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0010;
    tick();
    rst = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_tests++;
      if (rsp_valid !== 1'b0 || perf_issue_cnt !== 16'd0) begin
        n_fail++; $display("FAIL midflight_drop i=%0d got v=%b perf=%0d exp v=0 perf=0", i, rsp_valid, perf_issue_cnt);
      end
      tick();
    end
    req_valid = '1;
    repeat (5) tick();
    req_valid = '0;
    @(negedge clk);
    n_tests++;
    if (perf_issue_cnt !== (PERF ? 16'd5 : 16'd0)) begin
      n_fail++; $display("FAIL perf_count got=%0d exp=%0d", perf_issue_cnt, PERF ? 5 : 0);
    end
    repeat (5) tick();
  endtask

  task automatic test_random_fairness;
    int waited;
    bit got;
    for (int t = 0; t < 20; t++) begin
      waited = 0;
      got = 1'b0;
      for (int c = 0; c < NUM_REQ + 2 && !got; c++) begin
        rand_ops();
        req_valid = 4'($urandom) | 4'b1000;
        @(negedge clk);
        if (req_ready[3]) got = 1'b1;
        else waited++;
        tick();
      end
      n_tests++;
      if (!got || waited > NUM_REQ - 1) begin
        n_fail++; $display("FAIL fairness trial=%0d got_grant=%b waited=%0d max=%0d", t, got, waited, NUM_REQ - 1);
      end
    end
    for (int c = 0; c < 200; c++) begin
      rand_ops();
      req_valid = 4'($urandom);
      tick();
    end
    req_valid = '0;
    repeat (6) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap_skip();
    test_overflow();
    test_reset_midflight();
    test_random_fairness();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
